// File: rtl/serial_match_sequencer.sv
// ---------------------------------------------------------------------------
// serial_match_sequencer : bit-serial A/B sequencer with equal-bit run detect.
// Optional abort input enabled by defining SEQ_MATCH_ABORT_EN.  Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module serial_match_sequencer #(
  parameter int WIDTH   = 8,
  parameter int RUN_LEN = 4,
  localparam int RW     = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
`ifdef SEQ_MATCH_ABORT_EN
  input  logic             abort,
`endif
  input  logic             start,
  input  logic [WIDTH-1:0] word_a,
  input  logic [WIDTH-1:0] word_b,
  output logic             bit_a,
  output logic             bit_b,
  output logic             bit_valid,
  output logic             busy,
  output logic             done,
  output logic             run_found,
  output logic [RW-1:0]    max_run
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] sa_q, sa_d;
  logic [WIDTH-1:0] sb_q, sb_d;
  logic [RW-1:0]    cnt_q, cnt_d;
  logic [RW-1:0]    cur_run_q, cur_run_d;
  logic [RW-1:0]    max_run_q, max_run_d;
  logic             run_found_q, run_found_d;
  logic [RW-1:0]    cur_run_next;
  logic             abort_req;

`ifdef SEQ_MATCH_ABORT_EN
  assign abort_req = abort;
`else
  assign abort_req = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    sa_d         = sa_q;
    sb_d         = sb_q;
    cnt_d        = cnt_q;
    cur_run_d    = cur_run_q;
    max_run_d    = max_run_q;
    run_found_d  = run_found_q;
    cur_run_next = '0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          sa_d        = word_a;
          sb_d        = word_b;
          cnt_d       = '0;
          cur_run_d   = '0;
          max_run_d   = '0;
          run_found_d = 1'b0;
          state_d     = S_SHIFT;
        end
      end
      S_SHIFT: begin
        cur_run_next = (sa_q[0] == sb_q[0]) ? cur_run_q + 1'b1 : '0;
        cur_run_d    = cur_run_next;
        if (cur_run_next > max_run_q) max_run_d = cur_run_next;
        if (cur_run_next >= RW'(RUN_LEN)) run_found_d = 1'b1;
        sa_d  = sa_q >> 1;
        sb_d  = sb_q >> 1;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == RW'(WIDTH - 1)) state_d = S_DONE;
        // Abort still lets the bit of this cycle count toward the results.
        if (abort_req) state_d = S_IDLE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      sa_q        <= '0;
      sb_q        <= '0;
      cnt_q       <= '0;
      cur_run_q   <= '0;
      max_run_q   <= '0;
      run_found_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      sa_q        <= sa_d;
      sb_q        <= sb_d;
      cnt_q       <= cnt_d;
      cur_run_q   <= cur_run_d;
      max_run_q   <= max_run_d;
      run_found_q <= run_found_d;
    end
  end

  assign bit_a     = sa_q[0];
  assign bit_b     = sb_q[0];
  assign bit_valid = (state_q == S_SHIFT);
  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE);
  assign run_found = run_found_q;
  assign max_run   = max_run_q;

endmodule

`default_nettype wire

// File: tb/tb_serial_match_sequencer.sv
// Directed bench for serial_match_sequencer (WIDTH=8, RUN_LEN=4).
`default_nettype none

module tb_serial_match_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       abort;
  logic [7:0] word_a, word_b;
  logic       bit_a, bit_b, bit_valid, busy, done, run_found;
  logic [3:0] max_run;

  int passed = 0;
  int total  = 0;

  serial_match_sequencer #(.WIDTH(8), .RUN_LEN(4)) dut (
    .clk(clk),
    .reset(reset),
`ifdef SEQ_MATCH_ABORT_EN
    .abort(abort),
`endif
    .start(start),
    .word_a(word_a),
    .word_b(word_b),
    .bit_a(bit_a),
    .bit_b(bit_b),
    .bit_valid(bit_valid),
    .busy(busy),
    .done(done),
    .run_found(run_found),
    .max_run(max_run)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".busy"}, busy, 0);
    check({tag, ".done"}, done, 0);
    check({tag, ".bit_valid"}, bit_valid, 0);
    check({tag, ".bit_a"}, bit_a, 0);
    check({tag, ".bit_b"}, bit_b, 0);
    check({tag, ".run_found"}, run_found, 0);
    check({tag, ".max_run"}, max_run, 0);
  endtask

  // Issue one operation from IDLE (cycle 0) and check cycles 1..10.
  task automatic run_op(input logic [7:0] a, input logic [7:0] b,
                        input logic [3:0] exp_max, input logic exp_found);
    start = 1'b1; word_a = a; word_b = b;
    tick();
    start = 1'b0; word_a = 8'h00; word_b = 8'h00;
    for (int i = 0; i < 8; i++) begin
      check("shift.bit_valid", bit_valid, 1);
      check("shift.busy", busy, 1);
      check("shift.done", done, 0);
      check("shift.bit_a", bit_a, a[i]);
      check("shift.bit_b", bit_b, b[i]);
      tick();
    end
    check("done.done", done, 1);
    check("done.busy", busy, 1);
    check("done.bit_valid", bit_valid, 0);
    check("done.max_run", max_run, exp_max);
    check("done.run_found", run_found, exp_found);
    tick();
    check("idle.done", done, 0);
    check("idle.busy", busy, 0);
    check("idle.max_run_hold", max_run, exp_max);
    check("idle.run_found_hold", run_found, exp_found);
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; abort = 1'b0; word_a = 8'h00; word_b = 8'h00;
    #2;
    check_all_zero("reset");
    tick();
    reset = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      check("idle20.busy", busy, 0);
      check("idle20.done", done, 0);
    end

    run_op(8'hFF, 8'hFF, 4'd8, 1'b1);
    run_op(8'hAA, 8'h55, 4'd0, 1'b0);
    run_op(8'h00, 8'h88, 4'd3, 1'b0);
    run_op(8'h0F, 8'h07, 4'd4, 1'b1);

    // start held high: ops at cycles 0 and 10; operands change mid-op
    start = 1'b1; word_a = 8'h0F; word_b = 8'h07;
    tick();
    for (int i = 0; i < 8; i++) begin
      check("held1.bit_valid", bit_valid, 1);
      check("held1.bit_a", bit_a, (i < 4) ? 1 : 0);
      check("held1.bit_b", bit_b, (i < 3) ? 1 : 0);
      if (i == 2) begin word_a = 8'hFF; word_b = 8'hFF; end
      tick();
    end
    check("held1.done", done, 1);
    check("held1.max_run", max_run, 4);
    check("held1.run_found", run_found, 1);
    tick();
    check("held.idle_busy", busy, 0);
    check("held.idle_max_run", max_run, 4);
    tick();
    check("held2.bit_valid", bit_valid, 1);
    check("held2.max_run_cleared", max_run, 0);
    check("held2.run_found_cleared", run_found, 0);
    for (int i = 0; i < 8; i++) begin
      check("held2.bit_a", bit_a, 1);
      check("held2.done", done, 0);
      tick();
    end
    check("held2.done", done, 1);
    check("held2.max_run", max_run, 8);
    start = 1'b0;
    tick();
    check("held.end_busy", busy, 0);
    tick();
    check("held.end_busy2", busy, 0);

    // reset asserted in cycle 4 of an operation
    start = 1'b1; word_a = 8'hFF; word_b = 8'hFF;
    tick();
    start = 1'b0;
    tick(); tick(); tick();
    check("pre_reset.busy", busy, 1);
    check("pre_reset.max_run", max_run, 3);
    reset = 1'b0;
    #1;
    check_all_zero("midreset");
    tick();
    reset = 1'b1;
    for (int i = 0; i < 12; i++) begin
      check("post_reset.done", done, 0);
      check("post_reset.busy", busy, 0);
      tick();
    end
    check("post_reset.max_run", max_run, 0);

`ifdef SEQ_MATCH_ABORT_EN
    start = 1'b1; word_a = 8'hFF; word_b = 8'hFF;
    tick();
    start = 1'b0;
    tick(); tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort.busy", busy, 0);
    check("abort.done", done, 0);
    check("abort.max_run", max_run, 3);
    check("abort.run_found", run_found, 0);
    tick();
    check("abort.no_done", done, 0);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

`default_nettype wire
